// File: rtl/plot_writer_if.sv
// plot_writer_if: point input, clear control and framebuffer write bus.
// master: zoom stage / framebuffer side, slave: plot_writer.
interface plot_writer_if #(
   parameter int CW = 4
);
   logic              ENB;
   logic signed [7:0] XIN;
   logic signed [7:0] YIN;
   logic              VALID_IN;
   logic [CW-1:0]     COLOR;
   logic              CLR_REQ;
   logic [CW-1:0]     CLR_COLOR;
   logic [15:0]       WADDR;
   logic [CW-1:0]     WDATA;
   logic              WREQ;
   logic              WACK;
   logic              BUSY;
   logic              OVF;

   modport master (
      output ENB, XIN, YIN, VALID_IN, COLOR, CLR_REQ, CLR_COLOR, WACK,
      input  WADDR, WDATA, WREQ, BUSY, OVF
   );

   modport slave (
      input  ENB, XIN, YIN, VALID_IN, COLOR, CLR_REQ, CLR_COLOR, WACK,
      output WADDR, WDATA, WREQ, BUSY, OVF
   );
endinterface

// File: rtl/plot_writer.sv
// plot_writer: buffers signed (X,Y,colour) points in a FIFO, maps them onto a
// centred 256x256 framebuffer and issues one req/ack write per point; also
// sweeps the whole screen with a background colour on request.
// Optional feature macro: PLOT_DEDUP_EN (drop a point equal to the last pushed).
module plot_writer #(
   parameter int DEPTH = 8,
   parameter int CW    = 4
) (
   input logic          ACLK,
   input logic          ARESETN,
   plot_writer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int EW = 16 + CW;

   typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

   state_t        state_q;
   logic [EW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q, rd_nxt;
   logic [AW:0]   cnt_q, cnt_d;
   logic [EW-1:0] stage_q;
   logic          fetch_q;
   logic          clr_pend_q;
   logic [CW-1:0] pend_color_q;
   logic [15:0]   waddr_q;
   logic [CW-1:0] wdata_q;
   logic          wreq_q, busy_q, busy_d, ovf_q;

   logic [EW-1:0] pt, head, nxt;
   logic          offered, full, dup, push, retire, clr_now, clr_start, more;
   logic          idle_next, pend_next;

   // Entry layout {X, Y, COLOR}; address is {row, col} with centre origin.
   function automatic logic [15:0] map_addr(input logic [EW-1:0] e);
      logic [7:0] x, y, row, col;
      x   = e[EW-1 -: 8];
      y   = e[EW-9 -: 8];
      col = {~x[7], x[6:0]};
      row = 8'd127 - y;
      return {row, col};
   endfunction

   // Capture / FIFO bookkeeping terms. The in-flight write stays counted in
   // the FIFO until acknowledged, so a stalled write still occupies a slot.
   always_comb begin
      pt        = {bus.XIN, bus.YIN, bus.COLOR};
      offered   = bus.ENB & bus.VALID_IN;
      full      = (cnt_q == (AW+1)'(DEPTH));
      push      = offered & ~full & ~dup;
      retire    = (state_q == WRITE) & bus.WACK;
      clr_now   = clr_pend_q | bus.CLR_REQ;
      clr_start = (state_q == IDLE) & clr_now;
      more      = (cnt_q >= (AW+1)'(2));
      rd_nxt    = rd_q + 1'b1;
      head      = mem_q[rd_q];
      nxt       = mem_q[rd_nxt];
      cnt_d     = cnt_q + (AW+1)'(push) - (AW+1)'(retire);
   end

`ifdef PLOT_DEDUP_EN
   logic [EW-1:0] last_q;
   logic          last_vld_q;

   assign dup = offered & last_vld_q & (last_q == pt);

   // Remember the last pushed point; forgotten when a clear sweep starts.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         last_q     <= '0;
         last_vld_q <= 1'b0;
      end else if (clr_start) begin
         last_vld_q <= 1'b0;
      end else if (push) begin
         last_q     <= pt;
         last_vld_q <= 1'b1;
      end
   end
`else
   assign dup = 1'b0;
`endif

   // FIFO storage, no reset needed (validity tracked by pointers).
   always_ff @(posedge ACLK) begin
      if (push) mem_q[wr_q] <= pt;
   end

   // FIFO pointers, occupancy and sticky overflow.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         if (push)   wr_q <= wr_q + 1'b1;
         if (retire) rd_q <= rd_nxt;
         cnt_q <= cnt_d;
         if (offered & full & ~dup) ovf_q <= 1'b1;
      end
   end

   // Next-cycle BUSY: non-idle FSM, anything queued, or a clear still pending.
   always_comb begin
      idle_next = 1'b1;
      case (state_q)
         IDLE:    idle_next = ~clr_now & ~fetch_q;
         WRITE:   idle_next = bus.WACK & (clr_now | ~more);
         CLEAR:   idle_next = bus.WACK & (waddr_q == '1);
         default: idle_next = 1'b1;
      endcase
      pend_next = (state_q == IDLE) ? 1'b0 : clr_now;
      busy_d    = ~idle_next | (cnt_d != '0) | pend_next;
   end

   // Write/clear FSM with registered bus outputs. IDLE spends one cycle
   // staging the FIFO head before WRITE; entering CLEAR drops the stage and
   // the head is re-fetched afterwards, since it was never retired.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q      <= IDLE;
         waddr_q      <= '0;
         wdata_q      <= '0;
         wreq_q       <= 1'b0;
         busy_q       <= 1'b0;
         fetch_q      <= 1'b0;
         stage_q      <= '0;
         clr_pend_q   <= 1'b0;
         pend_color_q <= '0;
      end else begin
         busy_q <= busy_d;
         case (state_q)
            IDLE: begin
               if (clr_now) begin
                  state_q    <= CLEAR;
                  waddr_q    <= '0;
                  wdata_q    <= bus.CLR_REQ ? bus.CLR_COLOR : pend_color_q;
                  wreq_q     <= 1'b1;
                  fetch_q    <= 1'b0;
                  clr_pend_q <= 1'b0;
               end else if (fetch_q) begin
                  state_q <= WRITE;
                  waddr_q <= map_addr(stage_q);
                  wdata_q <= stage_q[CW-1:0];
                  wreq_q  <= 1'b1;
                  fetch_q <= 1'b0;
               end else if (cnt_q != '0) begin
                  stage_q <= head;
                  fetch_q <= 1'b1;
               end
            end
            WRITE: begin
               if (bus.CLR_REQ) begin
                  clr_pend_q   <= 1'b1;
                  pend_color_q <= bus.CLR_COLOR;
               end
               if (bus.WACK) begin
                  if (!clr_now && more) begin
                     waddr_q <= map_addr(nxt);
                     wdata_q <= nxt[CW-1:0];
                  end else begin
                     state_q <= IDLE;
                     wreq_q  <= 1'b0;
                  end
               end
            end
            CLEAR: begin
               if (bus.CLR_REQ) begin
                  clr_pend_q   <= 1'b1;
                  pend_color_q <= bus.CLR_COLOR;
               end
               if (bus.WACK) begin
                  if (waddr_q == '1) begin
                     state_q <= IDLE;
                     wreq_q  <= 1'b0;
                  end else begin
                     waddr_q <= waddr_q + 16'd1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               wreq_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.WADDR = waddr_q;
   assign bus.WDATA = wdata_q;
   assign bus.WREQ  = wreq_q;
   assign bus.BUSY  = busy_q;
   assign bus.OVF   = ovf_q;
endmodule

// File: tb/tb_plot_writer.sv
// tb_plot_writer: directed stimulus with a scoreboard queue of expected
// framebuffer writes; a negedge monitor checks every requested write.
module tb_plot_writer;
   typedef struct {
      logic [15:0] a;
      logic [3:0]  d;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   exp_t exp_q[$];

   plot_writer_if #(.CW(4)) bus ();

   plot_writer #(.DEPTH(8), .CW(4)) dut (
      .ACLK    (clk),
      .ARESETN (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Monitor: every requested write must match the scoreboard head; the head
   // is retired when the write is acknowledged on the next rising edge.
   always @(negedge clk) begin
      if (rst_n && bus.WREQ === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_wreq", {16'h0, bus.WADDR}, 32'hFFFF_FFFF);
         end else begin
            chk("waddr", {16'h0, bus.WADDR}, {16'h0, exp_q[0].a});
            chk("wdata", {28'h0, bus.WDATA}, {28'h0, exp_q[0].d});
            if (bus.WACK === 1'b1) void'(exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_add(input logic [15:0] a, input logic [3:0] d);
      exp_t e;
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic push_pt(input logic [7:0] x, input logic [7:0] y, input logic [3:0] c);
      bus.XIN      = x;
      bus.YIN      = y;
      bus.COLOR    = c;
      bus.ENB      = 1'b1;
      bus.VALID_IN = 1'b1;
      tick();
      bus.VALID_IN = 1'b0;
   endtask

   task automatic drain(input string nm, input int limit);
      logic done;
      done = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         #1;
         if (exp_q.size() == 0 && bus.BUSY === 1'b0) begin
            done = 1'b1;
            break;
         end
      end
      chk(nm, {31'h0, done}, 32'h1);
   endtask

   initial begin
      logic found;
      checks       = 0;
      failures     = 0;
      rst_n        = 1'b0;
      bus.ENB      = 1'b0;
      bus.XIN      = '0;
      bus.YIN      = '0;
      bus.VALID_IN = 1'b0;
      bus.COLOR    = '0;
      bus.CLR_REQ  = 1'b0;
      bus.CLR_COLOR = '0;
      bus.WACK     = 1'b1;
      #1;
      chk("rst_waddr", {16'h0, bus.WADDR}, 32'h0);
      chk("rst_wdata", {28'h0, bus.WDATA}, 32'h0);
      chk("rst_wreq",  {31'h0, bus.WREQ},  32'h0);
      chk("rst_busy",  {31'h0, bus.BUSY},  32'h0);
      chk("rst_ovf",   {31'h0, bus.OVF},   32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Single point at the origin: request appears two edges after capture.
      exp_add(16'h7F80, 4'd5);
      push_pt(8'h00, 8'h00, 4'd5);
      chk("lat_n0_wreq", {31'h0, bus.WREQ}, 32'h0);
      tick();
      chk("lat_n1_wreq", {31'h0, bus.WREQ}, 32'h0);
      tick();
      chk("lat_n2_wreq", {31'h0, bus.WREQ}, 32'h1);
      chk("lat_n2_waddr", {16'h0, bus.WADDR}, 32'h7F80);
      drain("drain_single", 20);

      // Screen corners, written in push order.
      exp_add(16'h0000, 4'd1);
      exp_add(16'hFFFF, 4'd2);
      exp_add(16'h807F, 4'd3);
      push_pt(8'h80, 8'h7F, 4'd1);
      push_pt(8'h7F, 8'h80, 4'd2);
      push_pt(8'hFF, 8'hFF, 4'd3);
      drain("drain_corners", 30);

      // Backpressure: stalled for 10 cycles, then three back-to-back writes.
      bus.WACK = 1'b0;
      exp_add(16'h7F8A, 4'd6);
      exp_add(16'h7F94, 4'd7);
      exp_add(16'h7F9E, 4'd8);
      push_pt(8'd10, 8'h00, 4'd6);
      push_pt(8'd20, 8'h00, 4'd7);
      push_pt(8'd30, 8'h00, 4'd8);
      for (int i = 0; i < 10; i++) tick();
      chk("bp_stalled_wreq", {31'h0, bus.WREQ}, 32'h1);
      bus.WACK = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_b2b_wreq", {31'h0, bus.WREQ}, 32'h1);
      end
      @(negedge clk);
      chk("bp_end_wreq", {31'h0, bus.WREQ}, 32'h0);
      drain("drain_bp", 20);

      // Overflow: 9 pushes into 8 slots while stalled; the 9th is lost.
      bus.WACK = 1'b0;
      for (int i = 0; i < 8; i++) exp_add(16'h7F80 + 16'(i), 4'(i));
      for (int i = 0; i < 9; i++) push_pt(8'(i), 8'h00, 4'(i));
      chk("ovf_set", {31'h0, bus.OVF}, 32'h1);
      tick();
      bus.WACK = 1'b1;
      drain("drain_ovf", 40);
      chk("ovf_sticky", {31'h0, bus.OVF}, 32'h1);

      // Clear request during a stalled write with two more points queued.
      bus.WACK = 1'b0;
      exp_add(16'h7E81, 4'd1);
      for (int i = 0; i < 65536; i++) exp_add(16'(i), 4'd3);
      exp_add(16'h7D82, 4'd2);
      exp_add(16'h7C83, 4'd4);
      push_pt(8'd1, 8'd1, 4'd1);
      push_pt(8'd2, 8'd2, 4'd2);
      push_pt(8'd3, 8'd3, 4'd4);
      tick();
      tick();
      chk("clr_in_write", {31'h0, bus.WREQ}, 32'h1);
      bus.CLR_COLOR = 4'd3;
      bus.CLR_REQ   = 1'b1;
      tick();
      bus.CLR_REQ   = 1'b0;
      bus.CLR_COLOR = 4'hA;
      tick();
      bus.WACK = 1'b1;
      drain("drain_clear", 70000);
      chk("clr_busy_low", {31'h0, bus.BUSY}, 32'h0);

      // Reset in the middle of a sweep, with a point captured during it.
      chk("ovf_before_rst", {31'h0, bus.OVF}, 32'h1);
      for (int i = 0; i < 8192; i++) exp_add(16'(i), 4'hC);
      bus.CLR_COLOR = 4'hC;
      bus.CLR_REQ   = 1'b1;
      tick();
      bus.CLR_REQ   = 1'b0;
      tick();
      push_pt(8'd40, 8'd40, 4'd7);
      found = 1'b0;
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         if (bus.WREQ === 1'b1 && bus.WADDR === 16'h1234) begin
            found = 1'b1;
            break;
         end
      end
      chk("reach_1234", {31'h0, found}, 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      chk("mrst_wreq", {31'h0, bus.WREQ}, 32'h0);
      chk("mrst_busy", {31'h0, bus.BUSY}, 32'h0);
      chk("mrst_ovf",  {31'h0, bus.OVF},  32'h0);
      chk("mrst_waddr", {16'h0, bus.WADDR}, 32'h0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      chk("post_rst_idle_wreq", {31'h0, bus.WREQ}, 32'h0);
      chk("post_rst_idle_busy", {31'h0, bus.BUSY}, 32'h0);

      // Same point twice in a row after reset.
      exp_add(16'h7A85, 4'd9);
`ifndef PLOT_DEDUP_EN
      exp_add(16'h7A85, 4'd9);
`endif
      push_pt(8'd5, 8'd5, 4'd9);
      push_pt(8'd5, 8'd5, 4'd9);
      bus.ENB = 1'b0;
      drain("drain_dup", 30);
      chk("dup_no_ovf", {31'h0, bus.OVF}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
